// File: rtl/mult_share_pkg.sv
// Shared FSM state type, default widths and the round-robin pick for mult_share_sequencer.
package mult_share_pkg;
  localparam int DEF_M    = 8;
  localparam int DEF_N    = 8;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = $clog2(DEF_NREQ);
  localparam int MAXREQ   = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One-hot grant on the first set bit of valid after 'last', wrapping at nreq.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid,
                                                input int unsigned       nreq,
                                                input int unsigned       last);
    logic [MAXREQ-1:0] grant;
    logic [4:0]        idx;
    grant = '0;
    for (int unsigned k = 1; k <= MAXREQ; k++) begin
      idx = 5'((last + k) % nreq);
      if (k <= nreq && grant == '0 && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction
endpackage

// File: rtl/mult_share_sequencer_core.sv
// Iterative shift-and-add multiplier: load captures operands, each step retires one multiplier bit.
// last_step flags the N-th step; acc holds the full product once that step has been taken.
module shift_add_core
  import mult_share_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [M-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [M+N-1:0] acc,
  output logic           last_step
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [M+N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      a_reg <= {{N{1'b0}}, a_in};
      b_reg <= b_in;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      // Always N steps, even once b_reg has run out of ones, so latency never depends on data.
      if (b_reg[0]) acc <= acc + a_reg;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

  assign last_step = step && (cnt == CW'(N - 1));
endmodule

// File: rtl/mult_share_sequencer.sv
// Round-robin front end sharing one shift-and-add multiplier among NREQ requesters.
// Grant to rsp_valid is N+1 cycles; req_ready stays low until the held response is taken.
module mult_share_sequencer
  import mult_share_pkg::*;
#(
  parameter int M    = DEF_M,
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*M-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [M+N-1:0]    rsp_product,
  output logic              busy
);
  state_t          state, state_next;
  logic [IDW-1:0]  last_grant, grant_idx, id_reg;
  logic [NREQ-1:0] grant;
  logic [M-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            load, step, last_step;
  logic [M+N-1:0]  acc;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (state == IDLE) grant = NREQ'(rr_pick(MAXREQ'(req_valid), NREQ, int'(last_grant)));
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDW'(i);
        sel_a     = req_a[i*M +: M];
        sel_b     = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (|grant) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_reg     <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        last_grant <= grant_idx;
        id_reg     <= grant_idx;
      end
    end
  end

  shift_add_core #(.M(M), .N(N)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a_in      (sel_a),
    .b_in      (sel_b),
    .acc       (acc),
    .last_step (last_step)
  );

  // Response fields are gated by DONE so reset clears them without waiting for a clock.
  assign req_ready   = grant;
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == DONE);
  assign rsp_id      = rsp_valid ? id_reg : '0;
  assign rsp_product = rsp_valid ? acc : '0;
endmodule

// File: tb/tb_mult_share_sequencer.sv
// Bench for mult_share_sequencer: transaction-level model checked every cycle plus directed literals.
module tb_mult_share_sequencer;
  localparam int M = 8, N = 8, NREQ = 4, IDW = 2;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*M-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [M+N-1:0]    rsp_product;
  logic [M-1:0]      op_a [NREQ];
  logic [N-1:0]      op_b [NREQ];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: phase 0 idle, 1..N multiplying, N+1 holding the response.
  int m_phase = 0;
  int m_ptr   = NREQ - 1;
  int m_id    = 0;
  int m_prod  = 0;

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  mult_share_sequencer #(.M(M), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (ptr + k) % NREQ;
      if (v[j[IDW-1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin : compare
    int pick;
    logic [NREQ-1:0] exp_ready;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        m_phase = 0;
        m_ptr   = NREQ - 1;
      end else begin
        pick      = (m_phase == 0) ? model_pick(req_valid, m_ptr) : -1;
        exp_ready = '0;
        if (pick >= 0) exp_ready[pick[IDW-1:0]] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, m_phase != 0);
        check("rsp_valid", rsp_valid, m_phase == N + 1);
        if (m_phase == N + 1) begin
          check("rsp_id", rsp_id, m_id);
          check("rsp_product", rsp_product, m_prod);
        end
        if (pick >= 0) begin
          m_id    = pick;
          m_ptr   = pick;
          m_prod  = int'(op_a[pick[IDW-1:0]]) * int'(op_b[pick[IDW-1:0]]);
          m_phase = 1;
        end else if (m_phase >= 1 && m_phase <= N) begin
          m_phase++;
        end else if (m_phase == N + 1 && rsp_ready) begin
          m_phase = 0;
        end
      end
    end
  end

  task automatic wait_grant(output int idx, output int at);
    idx = -1;
    at  = 0;
    for (int i = 0; i < 40 && idx < 0; i++) begin
      @(negedge clk);
      for (int j = 0; j < NREQ; j++)
        if (rst && req_ready[j[IDW-1:0]]) begin
          idx = j;
          at  = cyc;
        end
    end
    if (idx < 0) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int at);
    logic seen;
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen) check("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    if (!seen) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the block idle; leaves just after the handshake edge.
  task automatic do_op(input int r, input logic [7:0] a, input logic [7:0] b, input int exp_prod);
    int g, t, tr;
    op_a[r[IDW-1:0]]      = a;
    op_b[r[IDW-1:0]]      = b;
    req_valid[r[IDW-1:0]] = 1'b1;
    wait_grant(g, t);
    check("op_grant", g, r);
    @(posedge clk);
    #1;
    req_valid[r[IDW-1:0]] = 1'b0;
    wait_rsp(tr);
    check("op_latency", tr - t, N + 1);
    check("op_product", rsp_product, exp_prod);
    check("op_id", rsp_id, r);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int idx, t, tr, prev_t;
    logic [NREQ-1:0] seen;
    int bnd [4][3] = '{'{255, 255, 16'hFE01}, '{0, 200, 0}, '{2, 63, 126}, '{1, 128, 128}};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #2 rst = 1'b0;
    #1;
    check("init_busy", busy, 0);
    check("init_rsp_valid", rsp_valid, 0);
    check("init_rsp_product", rsp_product, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rsp_ready = 1'b1;

    // Single requester after reset, then operand boundaries through requester 2.
    do_op(0, 8'd13, 8'd11, 143);
    for (int i = 0; i < 4; i++) do_op(2, 8'(bnd[i][0]), 8'(bnd[i][1]), bnd[i][2]);

    // All requesters valid straight out of reset.
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 8'(10 * (i + 1));
      op_b[i] = 8'(2 * i + 3);
    end
    req_valid = '1;
    @(posedge clk);
    #1 rst = 1'b1;
    prev_t = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(idx, t);
      check("rr_order", idx, g % NREQ);
      if (g > 0) check("rr_spacing", t - prev_t, N + 2);
      prev_t = t;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    wait_idle();

    // Response held under backpressure while other requesters wait.
    op_a[0] = 8'd7;
    op_b[0] = 8'd9;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    wait_grant(idx, t);
    @(posedge clk);
    #1;
    op_a[1] = 8'd3;
    op_b[1] = 8'd4;
    req_valid = 4'b1010;
    wait_rsp(tr);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_product", rsp_product, 63);
      check("hold_id", rsp_id, 0);
      check("hold_ready", req_ready, 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", rsp_valid, 1);
    @(negedge clk);
    check("after_hold_busy", busy, 0);
    check("after_hold_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Asynchronous reset in the middle of a multiply.
    op_a[0] = 8'd200;
    op_b[0] = 8'd100;
    req_valid = 4'b0001;
    wait_grant(idx, t);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_product", rsp_product, 0);
    op_a[0] = 8'd9;
    op_b[0] = 8'd9;
    op_a[3] = 8'd5;
    op_b[3] = 8'd6;
    req_valid = 4'b1001;
    @(posedge clk);
    #2 rst = 1'b1;
    wait_grant(idx, t);
    check("post_reset_grant", idx, 0);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(tr);
    check("post_reset_product", rsp_product, 81);
    check("post_reset_id", rsp_id, 0);
    wait_idle();

    // A valid pulse during RUN must not leave a pending grant behind.
    op_a[0] = 8'd4;
    op_b[0] = 8'd4;
    req_valid = 4'b0001;
    wait_grant(idx, t);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
    op_a[3] = 8'd11;
    op_b[3] = 8'd12;
    req_valid = 4'b1000;
    wait_grant(idx, t);
    check("pulse_grant", idx, 3);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Random traffic and backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      seen = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (seen[i[IDW-1:0]]) begin
          req_valid[i[IDW-1:0]] = 1'($urandom_range(0, 1));
          op_a[i[IDW-1:0]] = rand_op();
          op_b[i[IDW-1:0]] = rand_op();
        end else if (!req_valid[i[IDW-1:0]]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i[IDW-1:0]] = 1'b1;
            op_a[i[IDW-1:0]] = rand_op();
            op_b[i[IDW-1:0]] = rand_op();
          end
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i[IDW-1:0]] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_sequencer.md
Name: mult_share_sequencer

Overview:
- Round-robin sequencer that shares one iterative shift-and-add multiplier core among NREQ requesters.
- Each requester presents an unsigned operand pair over a valid/ready handshake.
- The block grants one requester and runs the multiply one bit per cycle for N cycles.
- It returns the full-width product tagged with the requester ID over a valid/ready response channel.

Parameters:
- M, 8, width of operand A (multiplicand).
- N, 8, width of operand B (multiplier); also the number of iteration cycles.
- NREQ, 4, number of requesters (power of 2, >=2).
- IDW, 2, requester ID width = log2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*M  packed operand A; slice i belongs to requester i.
- req_b  input  NREQ*N  packed operand B; slice i belongs to requester i.
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_product.
- rsp_product  output  M+N  unsigned A*B, full width, never truncated.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; rsp_valid=0, rsp_id=0, rsp_product=0, busy=0; accumulator, operand and count registers cleared; last_grant=NREQ-1, so requester 0 has highest priority after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first valid requester, searching from (last_grant+1) mod NREQ with wrap-around.
  - On that edge the block captures a_reg={N'b0,A}, b_reg=B, id_reg=index, acc=0, cnt=0, and updates last_grant=index. Next state is RUN.
  - With no req_valid, the block stays in IDLE.
- RUN, each cycle:
  - if b_reg[0], acc <= acc + a_reg (M+N-bit add, no overflow possible);
  - a_reg <= a_reg<<1; b_reg <= b_reg>>1; cnt <= cnt+1.
  - When cnt==N-1, go to DONE.
  - There is always exactly N cycles in RUN; no early exit on b_reg==0. Latency is deterministic.
- DONE:
  - rsp_valid=1; rsp_product=acc; rsp_id=id_reg.
  - All three are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge, go to IDLE; rsp_valid drops the next cycle.
- req_ready is 0 in RUN and DONE. No request is accepted while the core is occupied.
- Timing:
  - Grant edge at cycle t; rsp_valid rises at t+N+1.
  - Minimum issue interval is N+2 cycles; there is one IDLE bubble after each response.
- Requesters must hold valid and data stable until req_ready. Dropping valid before grant is legal and produces no grant.
- A pending requester waits at most NREQ-1 operations (starvation-free).
- Simultaneous events:
  - rsp handshake in DONE plus a new req_valid: the new grant occurs in the following IDLE cycle, never the same cycle.
  - req_valid changes in RUN/DONE are ignored.
- rsp_ready high with rsp_valid low has no effect.
- Reset mid-RUN or mid-DONE:
  - the operation is aborted and its response is never emitted;
  - outputs are forced to reset values immediately (async);
  - the arbitration pointer returns to its reset value.
- No operand value is special-cased. B=63, B=0 and all-ones operands go through the same path.

Decomposition:
- Package mult_share_pkg:
  - state enum (IDLE, RUN, DONE);
  - default widths M, N, NREQ and derived IDW;
  - function rr_pick(valid, last) returning a one-hot grant.
- Sub-module shift_add_core:
  - load/step interface; holds a_reg, b_reg, acc, cnt; asserts last_step when cnt==N-1.
  - The sequencer owns the arbiter, FSM and response registers.

Test Plan:
- Only req0 valid after reset, A=13, B=11 -> req_ready=4'b0001 at grant edge t; rsp_valid at t+9; rsp_product=143; rsp_id=0.
- Boundaries via req2:
  - A=255, B=255 -> 16'hFE01;
  - A=0, B=200 -> 0;
  - A=2, B=63 -> 126;
  - A=1, B=128 -> 128.
  - rsp_id=2 for each.
- All four req_valid held high from reset, rsp_ready=1 -> grants in order 0,1,2,3,0; distinct operands per requester return correct products with matching rsp_id; grant spacing exactly N+2=10 cycles.
- rsp_ready held 0 for 5 cycles in DONE, A=7, B=9 -> rsp_valid, rsp_product=63 and rsp_id stable for all 5 cycles; req_ready stays 0 despite other req_valid; IDLE is entered after rsp_ready=1.
- rst driven 0 asynchronously mid-cycle at cnt=4 of RUN -> busy, rsp_valid and rsp_product drop to 0 without waiting for clk; no response for the aborted op. After release with req0 and req3 valid, req0 is granted first.
- req1 pulses valid for one cycle while the block is in RUN, then drops -> no grant to req1; the next IDLE grants only currently-valid requesters.
